// File: rtl/instruction_decode_pipe.sv
// Instruction decode stage with ID/EX pipeline register.
//
// Decodes a 32-bit RV32I-subset instruction (lw, sw, R-type, I-arith, beq,
// jal, lui), reads two operands from a 2**REG_AW-entry register file with
// same-cycle write-through bypass, and registers the result into the ID/EX
// stage.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   InstrD, PCD              instruction being decoded and its PC
//   RegWriteW, RDW, ResultW  writeback port into the register file
//   StallE, FlushE           hold / bubble the ID/EX register (flush wins)
//   RS1D, RS2D               combinational source register fields (hazard unit)
//   *E outputs               registered decode results for the execute stage
module instruction_decode_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              StallE,
  input  logic              FlushE,
  output logic [REG_AW-1:0] RS1D,
  output logic [REG_AW-1:0] RS2D,
  output logic              RegWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [3:0]        ALUControlE,
  output logic [REG_AW-1:0] RDE,
  output logic [REG_AW-1:0] RS1E,
  output logic [REG_AW-1:0] RS2E,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   ImmExtE
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam int NREGS = 2**REG_AW;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              alu_src;
    logic [3:0]        alu_control;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm_ext;
  } idex_t;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;

  logic [XLEN-1:0]   rf [NREGS];
  logic              wb_en;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;

  logic              reg_write;
  logic [1:0]        result_src;
  logic              mem_write;
  logic              jump;
  logic              branch;
  logic              alu_src;
  logic [3:0]        alu_control;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm_ext;

  idex_t             idex_d;
  idex_t             idex_q;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7_5 = InstrD[30];
  assign rs1      = InstrD[15 +: REG_AW];
  assign rs2      = InstrD[20 +: REG_AW];
  assign rd       = InstrD[7 +: REG_AW];

  assign RS1D = rs1;
  assign RS2D = rs2;

  // ---------------- register file ----------------
  // x0 is never written, so it stays at its reset value of zero.
  assign wb_en = RegWriteW && (RDW != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[RDW] <= ResultW;
    end
  end

  // Write-through: a reader in the same cycle as the write sees the new value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) rd1 = (wb_en && (RDW == rs1)) ? ResultW : rf[rs1];
    if (rs2 != '0) rd2 = (wb_en && (RDW == rs2)) ? ResultW : rf[rs2];
  end

  // ---------------- control decode ----------------
  always_comb begin
    reg_write   = 1'b0;
    result_src  = 2'b00;
    mem_write   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    alu_src     = 1'b0;
    alu_control = ALU_ADD;
    unique case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        alu_src    = 1'b1;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_R, OP_I: begin
        reg_write = 1'b1;
        alu_src   = (opcode == OP_I);
        case (funct3)
          3'b000:  alu_control = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      OP_BEQ: begin
        branch      = 1'b1;
        alu_control = ALU_SUB;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        result_src = 2'b10;
        jump       = 1'b1;
      end
      OP_LUI: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = ALU_PASSB;
      end
      default: ;
    endcase
  end

  // ---------------- immediate generation ----------------
  // Built as a sign-correct 32-bit value first, then widened to XLEN.
  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_LW, OP_I: imm32 = {{20{InstrD[31]}}, InstrD[31:20]};
      OP_SW:       imm32 = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      OP_BEQ:      imm32 = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                            InstrD[30:25], InstrD[11:8], 1'b0};
      OP_JAL:      imm32 = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                            InstrD[20], InstrD[30:21], 1'b0};
      OP_LUI:      imm32 = {InstrD[31:12], 12'b0};
      default:     imm32 = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_imm_narrow
      assign imm_ext = imm32[XLEN-1:0];
    end
  endgenerate

  // ---------------- ID/EX register ----------------
  always_comb begin
    idex_d             = '0;
    idex_d.reg_write   = reg_write;
    idex_d.result_src  = result_src;
    idex_d.mem_write   = mem_write;
    idex_d.jump        = jump;
    idex_d.branch      = branch;
    idex_d.alu_src     = alu_src;
    idex_d.alu_control = alu_control;
    idex_d.rd          = rd;
    idex_d.rs1         = rs1;
    idex_d.rs2         = rs2;
    idex_d.rd1         = rd1;
    idex_d.rd2         = rd2;
    idex_d.pc          = PCD;
    idex_d.imm_ext     = imm_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= '0;
    end else if (FlushE) begin
      idex_q <= '0;
    end else if (!StallE) begin
      idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.reg_write;
  assign ResultSrcE  = idex_q.result_src;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ALUControlE = idex_q.alu_control;
  assign RDE         = idex_q.rd;
  assign RS1E        = idex_q.rs1;
  assign RS2E        = idex_q.rs2;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign PCE         = idex_q.pc;
  assign ImmExtE     = idex_q.imm_ext;

endmodule

// File: tb/tb_instruction_decode_pipe.sv
module tb_instruction_decode_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        StallE;
  logic        FlushE;
  logic [4:0]  RS1D, RS2D;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [4:0]  RDE, RS1E, RS2E;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE;

  // 64-bit build, driven by the same stimulus
  logic [63:0] pcd64, resultw64;
  logic [4:0]  w_rs1d, w_rs2d;
  logic        w_regwrite, w_memwrite, w_jump, w_branch, w_alusrc;
  logic [1:0]  w_resultsrc;
  logic [3:0]  w_aluctl;
  logic [4:0]  w_rde, w_rs1e, w_rs2e;
  logic [63:0] w_rd1e, w_rd2e, w_pce, w_immext;

  int checks   = 0;
  int failures = 0;

  assign pcd64     = {32'b0, PCD};
  assign resultw64 = {32'b0, ResultW};

  instruction_decode_pipe dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .StallE(StallE), .FlushE(FlushE), .RS1D(RS1D), .RS2D(RS2D),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RDE(RDE), .RS1E(RS1E), .RS2E(RS2E),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE)
  );

  instruction_decode_pipe #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(pcd64),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(resultw64),
    .StallE(StallE), .FlushE(FlushE), .RS1D(w_rs1d), .RS2D(w_rs2d),
    .RegWriteE(w_regwrite), .ResultSrcE(w_resultsrc), .MemWriteE(w_memwrite),
    .JumpE(w_jump), .BranchE(w_branch), .ALUSrcE(w_alusrc),
    .ALUControlE(w_aluctl), .RDE(w_rde), .RS1E(w_rs1e), .RS2E(w_rs2e),
    .RD1E(w_rd1e), .RD2E(w_rd2e), .PCE(w_pce), .ImmExtE(w_immext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle to the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; InstrD = '0; PCD = '0; RegWriteW = 1'b0; RDW = '0;
    ResultW = '0; StallE = 1'b0; FlushE = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_regwrite", {63'b0, RegWriteE}, 64'd0);
    chk("rst_imm", {32'b0, ImmExtE}, 64'd0);
    rst = 1'b1;

    // preload x1=0x11, x2=0x22 (bubble instruction in decode)
    RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'h11; tick();
    RDW = 5'd2; ResultW = 32'h22; tick();
    chk("bubble_regwrite", {63'b0, RegWriteE}, 64'd0);

    // addi x7, x3, -9 with x3 written in the same cycle (bypass)
    RDW = 5'd3; ResultW = 32'hABABABAB; InstrD = 32'hFF718393; PCD = 32'h8;
    chk("rs1d_comb", {59'b0, RS1D}, 64'd3);
    tick();
    RegWriteW = 1'b0;
    chk("byp_rd1", {32'b0, RD1E}, 64'hABABABAB);
    chk("addi_imm", {32'b0, ImmExtE}, 64'hFFFFFFF7);
    chk("addi_alu", {60'b0, ALUControlE}, 64'd0);
    chk("addi_rd", {59'b0, RDE}, 64'd7);
    chk("addi_alusrc", {63'b0, ALUSrcE}, 64'd1);
    chk("addi_regwrite", {63'b0, RegWriteE}, 64'd1);

    // beq x1, x2, -8
    InstrD = 32'hFE208CE3; PCD = 32'hC; tick();
    chk("beq_branch", {63'b0, BranchE}, 64'd1);
    chk("beq_alu", {60'b0, ALUControlE}, 64'd1);
    chk("beq_imm", {32'b0, ImmExtE}, 64'hFFFFFFF8);
    chk("beq_pc", {32'b0, PCE}, 64'hC);
    chk("beq_rd1", {32'b0, RD1E}, 64'h11);
    chk("beq_rd2", {32'b0, RD2E}, 64'h22);
    chk("beq_regwrite", {63'b0, RegWriteE}, 64'd0);

    // lw x4, 5(x2)
    InstrD = 32'h00512203; PCD = 32'h10; tick();
    chk("lw_resultsrc", {62'b0, ResultSrcE}, 64'd1);
    chk("lw_imm", {32'b0, ImmExtE}, 64'd5);
    chk("lw_rd", {59'b0, RDE}, 64'd4);
    chk("lw_rd1", {32'b0, RD1E}, 64'h22);

    // sra x3, x1, x2
    InstrD = 32'h4020D1B3; tick();
    chk("sra_alu", {60'b0, ALUControlE}, 64'd8);
    chk("sra_imm", {32'b0, ImmExtE}, 64'd0);
    chk("sra_alusrc", {63'b0, ALUSrcE}, 64'd0);

    // sub x3, x1, x2
    InstrD = 32'h402081B3; tick();
    chk("sub_alu", {60'b0, ALUControlE}, 64'd1);

    // addi with imm bit 30 set: never sub
    InstrD = 32'h40000293; tick();
    chk("addi_nosub", {60'b0, ALUControlE}, 64'd0);

    // lui x3, 0x12345
    InstrD = 32'h123451B7; tick();
    chk("lui_imm", {32'b0, ImmExtE}, 64'h12345000);
    chk("lui_alu", {60'b0, ALUControlE}, 64'd10);
    chk("lui_imm64", w_immext, 64'h0000000012345000);

    // lui with bit 31 set: sign-extends into upper half on 64-bit build
    InstrD = 32'h800000B7; tick();
    chk("lui_neg_imm", {32'b0, ImmExtE}, 64'h80000000);
    chk("lui_neg_imm64", w_immext, 64'hFFFFFFFF80000000);

    // jal x1, 8
    InstrD = 32'h008000EF; PCD = 32'h20; tick();
    chk("jal_jump", {63'b0, JumpE}, 64'd1);
    chk("jal_resultsrc", {62'b0, ResultSrcE}, 64'd2);
    chk("jal_imm", {32'b0, ImmExtE}, 64'd8);

    // stall with new instruction (sw x1, 4(x2)): E holds jal
    StallE = 1'b1; InstrD = 32'h00112223; PCD = 32'h24; tick();
    chk("stall_jump", {63'b0, JumpE}, 64'd1);
    chk("stall_imm", {32'b0, ImmExtE}, 64'd8);
    chk("stall_pc", {32'b0, PCE}, 64'h20);
    StallE = 1'b0; tick();
    chk("sw_memwrite", {63'b0, MemWriteE}, 64'd1);
    chk("sw_imm", {32'b0, ImmExtE}, 64'd4);
    chk("sw_regwrite", {63'b0, RegWriteE}, 64'd0);

    // stall + flush together: bubble
    StallE = 1'b1; FlushE = 1'b1; InstrD = 32'hFF718393; tick();
    chk("flush_memwrite", {63'b0, MemWriteE}, 64'd0);
    chk("flush_regwrite", {63'b0, RegWriteE}, 64'd0);
    chk("flush_imm", {32'b0, ImmExtE}, 64'd0);
    chk("flush_pc", {32'b0, PCE}, 64'd0);
    chk("flush_rd", {59'b0, RDE}, 64'd0);
    StallE = 1'b0; FlushE = 1'b0;

    // unknown opcode: all-zero controls
    InstrD = 32'h00000FFF; tick();
    chk("unk_regwrite", {63'b0, RegWriteE}, 64'd0);
    chk("unk_alusrc", {63'b0, ALUSrcE}, 64'd0);
    chk("unk_rd", {59'b0, RDE}, 64'd31);

    // write to x0 is discarded, bypass included
    RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'hFFFFFFFF;
    InstrD = 32'h00000293; tick();
    chk("x0_byp_rd1", {32'b0, RD1E}, 64'd0);
    RegWriteW = 1'b0; tick();
    chk("x0_rd1", {32'b0, RD1E}, 64'd0);

    // async reset mid-cycle with non-zero E outputs
    InstrD = 32'h123451B7; PCD = 32'h40; tick();
    chk("pre_rst_regwrite", {63'b0, RegWriteE}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_regwrite", {63'b0, RegWriteE}, 64'd0);
    chk("async_imm", {32'b0, ImmExtE}, 64'd0);
    chk("async_pc", {32'b0, PCE}, 64'd0);
    // a write attempted during reset is ignored
    RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'h55;
    tick();
    RegWriteW = 1'b0; rst = 1'b1;

    // first edge after release loads normally; x3 reads as 0
    InstrD = 32'hFF718393; PCD = 32'h44; tick();
    chk("post_rst_rd1_x3", {32'b0, RD1E}, 64'd0);
    chk("post_rst_pc", {32'b0, PCE}, 64'h44);
    // addi x6, x5, 0: x5 write during reset must not have landed
    InstrD = 32'h00028313; tick();
    chk("rst_write_ignored", {32'b0, RD1E}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
